spi_reg_bank: RTL

SPI target (mode 0, write-centric) that sits directly upstream of pwm_peripheral and owns its five configuration registers.
- Receives 16-bit frames on sclk/copi/ncs from the tile input pins.
- Synchronises them into the clk domain and decodes write commands.
- Drives en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle.

---
 rtl/spi_reg_bank.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/spi_reg_bank.sv
// SPI mode-0 target owning the five pwm_peripheral configuration registers.
// Optional register readback over cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_bank #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam logic [6:0] MaxAddr = 7'(MAX_ADDR);
  localparam logic [4:0] CntFull = 5'd16;
  localparam logic [4:0] CntOvf  = 5'd17;

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  // Each chain is SYNC_STAGES synchronisers plus one edge-detect flop on top.
  logic [SYNC_STAGES:0] sclk_q, copi_q, ncs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      copi_q <= '0;
      ncs_q  <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk};
      copi_q <= {copi_q[SYNC_STAGES-1:0], copi};
      ncs_q  <= {ncs_q[SYNC_STAGES-1:0], ncs};
    end
  end

  logic sclk_rise, ncs_rise, ncs_fall, ncs_lvl, copi_lvl;
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign ncs_rise  = ncs_q[SYNC_STAGES-1] & ~ncs_q[SYNC_STAGES];
  assign ncs_fall  = ~ncs_q[SYNC_STAGES-1] & ncs_q[SYNC_STAGES];
  assign ncs_lvl   = ncs_q[SYNC_STAGES-1];
  // copi is held across the whole sclk low phase, so the older copy is stable at the rise.
  assign copi_lvl  = copi_q[SYNC_STAGES];

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [15:0] shift_q;
  logic        pending_q;
  logic [7:0]  regs_q [5];

  logic       rw;
  logic [6:0] addr;
  logic [7:0] data;
  logic       frame_ok;
  assign rw       = shift_q[15];
  assign addr     = shift_q[14:8];
  assign data     = shift_q[7:0];
  assign frame_ok = (cnt_q == CntFull) && rw && (addr <= MaxAddr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      pending_q <= 1'b0;
      for (int i = 0; i < 5; i++) regs_q[i] <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ncs_fall || pending_q) begin
            state_q   <= StShift;
            cnt_q     <= '0;
            shift_q   <= '0;
            pending_q <= 1'b0;
          end
        end
        StShift: begin
          if (ncs_rise) begin
            state_q <= frame_ok ? StCommit : StIdle;
          end else if (sclk_rise && !ncs_lvl) begin
            shift_q <= {shift_q[14:0], copi_lvl};
            if (cnt_q != CntOvf) cnt_q <= cnt_q + 5'd1;
          end
        end
        StCommit: begin
          case (addr)
            7'd0:    regs_q[0] <= data;
            7'd1:    regs_q[1] <= data;
            7'd2:    regs_q[2] <= data;
            7'd3:    regs_q[3] <= data;
            7'd4:    regs_q[4] <= data;
            default: ;
          endcase
          // A new frame starting during the commit cycle is picked up by IDLE next cycle.
          pending_q <= ncs_fall;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [7:0] out_shift_q;
  logic       rd_rw;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;

  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
  // Header byte as it will stand once the 8th bit is shifted in.
  assign rd_rw     = shift_q[6];
  assign rd_addr   = {shift_q[5:0], copi_lvl};

  always_comb begin
    rd_data = 8'h00;
    if (!rd_rw && (rd_addr <= MaxAddr)) begin
      case (rd_addr)
        7'd0:    rd_data = regs_q[0];
        7'd1:    rd_data = regs_q[1];
        7'd2:    rd_data = regs_q[2];
        7'd3:    rd_data = regs_q[3];
        7'd4:    rd_data = regs_q[4];
        default: rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_shift_q <= 8'h00;
    end else if (ncs_rise) begin
      out_shift_q <= 8'h00;
    end else if (state_q == StShift && !ncs_lvl) begin
      if (sclk_rise && cnt_q == 5'd7) begin
        out_shift_q <= rd_data;
      end else if (sclk_fall && cnt_q >= 5'd9) begin
        out_shift_q <= {out_shift_q[6:0], 1'b0};
      end
    end
  end

  assign cipo = out_shift_q[7];
`else
  assign cipo = 1'b0;
`endif

endmodule
